trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Responder for the decoder's `trap` and HALT outputs.
- Sits between decode and the fetch/PC logic. On an illegal-opcode trap or a HALT it freezes the pipeline, flushes younger instructions, latches exception state, raises an IRQ to the host driver, and waits for the host handshake.
- After the handshake it redirects fetch to the trap vector (trap) or to the instruction after HALT (halt resume).

Parameters:
- XLEN, 32, datapath and PC width.
- TRAP_VECTOR, 32'h0000_0100, fetch target after an acknowledged trap.
- CNT_W, 16, width of the saturating trap counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  decode stage holds a valid instruction this cycle.
- trap_in  in  1  illegal-opcode flag from decode.
- halt_in  in  1  HALT opcode (7'b1111011) decoded.
- pc_in  in  XLEN  PC of the decode-stage instruction.
- instr_in  in  32  raw instruction word in decode.
- host_ack  in  1  host has taken the IRQ.
- host_resume  in  1  host releases a halted core.
- stall  out  1  freeze fetch/decode.
- flush  out  1  kill the decode-stage and younger instructions.
- irq  out  1  interrupt request to host.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  XLEN  redirect target.
- cause  out  4  4'd2 = illegal instruction, 4'd3 = halt, 0 = none.
- epc  out  XLEN  PC of the faulting or halting instruction.
- tval  out  32  instruction word of the faulting or halting instruction.
- halted  out  1  core is parked in HALTED.
- trap_count  out  CNT_W  number of traps taken, saturating.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-sequence):
  - State goes to RUN.
  - Every output resets to 0, including cause, epc, tval, redirect_pc and trap_count.
- Events are sampled only in RUN and only when valid_in=1. With valid_in=0, trap_in and halt_in are ignored; this covers post-reset opcode-0 bubbles.
- If trap_in and halt_in are both 1, trap wins (cause=2).

State machine:
- RUN
  - stall=0, irq=0, halted=0.
  - On an event at edge N: latch epc<=pc_in, tval<=instr_in, and cause. Increment trap_count (trap only; it saturates at all-ones and does not wrap). Go to FLUSH.
- FLUSH
  - Lasts exactly 1 cycle: flush=1 and stall=1 in cycle N+1.
  - Then go to NOTIFY.
- NOTIFY
  - stall=1 and irq=1 from cycle N+2 onward, held until host_ack=1 is sampled. host_ack is ignored outside NOTIFY.
  - On ack, irq drops on the next cycle.
  - If cause=2: go to REDIRECT with target TRAP_VECTOR.
  - If cause=3: go to HALTED.
- HALTED
  - stall=1, halted=1.
  - When host_resume is sampled: go to REDIRECT with target epc+4 (modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0).
  - host_resume is ignored in every other state.
- REDIRECT
  - Lasts 1 cycle: redirect_valid=1, redirect_pc=target, stall=1.
  - Then go to RUN, which clears stall.
  - redirect_pc holds its last value afterward and is meaningful only while redirect_valid=1.

Further rules:
- cause, epc and tval hold until the next event overwrites them. They are not cleared on return to RUN.
- Events arriving in any non-RUN state are dropped; decode is stalled, so none are legitimately presented.
- Minimum latency from event to redirect for a trap is 4 cycles, assuming host_ack arrives in the first NOTIFY cycle.
- If host_ack and host_resume arrive together in NOTIFY for a halt: the ack is taken, the resume is ignored, and the core enters HALTED and needs a later resume.

Test Plan:
- Reset mid-NOTIFY (irq=1): assert rst asynchronously → all outputs 0 immediately, state RUN, trap_count=0.
- valid_in=1, trap_in=1, pc_in=32'h40, instr_in=32'h0000_0000; host_ack in the first NOTIFY cycle:
  - flush=1 at N+1, irq=1 at N+2.
  - redirect_valid=1 with redirect_pc=32'h100 at N+4.
  - epc=32'h40, cause=2, trap_count=1.
- valid_in=1, halt_in=1, pc_in=32'h80; ack after 5 cycles, resume 3 cycles later:
  - irq is held for all 5 cycles.
  - halted=1 until the resume, then redirect_pc=32'h84.
  - cause=3, trap_count unchanged.
- trap_in=1 with valid_in=0 → no response (stall=0, trap_count=0). trap_in and halt_in both 1 with valid_in=1 → cause=2, and redirect goes to TRAP_VECTOR.
- Halt at pc_in=32'hFFFF_FFFC, then ack and resume → redirect_pc=0.
- 70000 back-to-back acknowledged traps with CNT_W=16 → trap_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/trap_controller.sv
// Trap/HALT responder: freezes and flushes the pipe, latches exception state,
// raises an IRQ, waits on the host, then redirects fetch.
module trap_controller #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  TRAP_VECTOR = 32'h0000_0100,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             trap_in,
  input  logic             halt_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [31:0]      instr_in,
  input  logic             host_ack,
  input  logic             host_resume,
  output logic             stall,
  output logic             flush,
  output logic             irq,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [3:0]       cause,
  output logic [XLEN-1:0]  epc,
  output logic [31:0]      tval,
  output logic             halted,
  output logic [CNT_W-1:0] trap_count
);

  localparam logic [3:0] CAUSE_ILL  = 4'd2;
  localparam logic [3:0] CAUSE_HALT = 4'd3;

  // SETTLE is the cycle after a trap ack: irq is already low, fetch not yet moved.
  typedef enum logic [2:0] {RUN, FLUSH, NOTIFY, SETTLE, HALTED, REDIRECT} state_t;
  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      stall          <= 1'b0;
      flush          <= 1'b0;
      irq            <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cause          <= '0;
      epc            <= '0;
      tval           <= '0;
      halted         <= 1'b0;
      trap_count     <= '0;
    end else begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        RUN: begin
          stall <= 1'b0;
          if (valid_in && (trap_in || halt_in)) begin
            epc   <= pc_in;
            tval  <= instr_in;
            cause <= trap_in ? CAUSE_ILL : CAUSE_HALT;
            if (trap_in && trap_count != '1) trap_count <= trap_count + 1'b1;
            flush <= 1'b1;
            stall <= 1'b1;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          irq   <= 1'b1;
          state <= NOTIFY;
        end
        NOTIFY: begin
          if (host_ack) begin
            irq <= 1'b0;
            if (cause == CAUSE_ILL) begin
              state <= SETTLE;
            end else begin
              halted <= 1'b1;
              state  <= HALTED;
            end
          end
        end
        SETTLE: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= TRAP_VECTOR;
          state          <= REDIRECT;
        end
        HALTED: begin
          if (host_resume) begin
            halted         <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= epc + XLEN'(4);
            state          <= REDIRECT;
          end
        end
        REDIRECT: begin
          stall <= 1'b0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed scenarios then randomized transactions
// checked against a transaction-level model of the trap/halt protocol.
module tb_trap_controller;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk = 1'b0, rst = 1'b0;
  logic valid_in = 1'b0, trap_in = 1'b0, halt_in = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic host_ack = 1'b0, host_resume = 1'b0;
  logic stall, flush, irq, redirect_valid, halted;
  logic [XLEN-1:0] redirect_pc, epc;
  logic [3:0] cause;
  logic [31:0] tval;
  logic [CNT_W-1:0] trap_count;

  trap_controller #(.XLEN(XLEN), .TRAP_VECTOR(TV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .trap_in(trap_in), .halt_in(halt_in),
    .pc_in(pc_in), .instr_in(instr_in), .host_ack(host_ack), .host_resume(host_resume),
    .stall(stall), .flush(flush), .irq(irq), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .cause(cause), .epc(epc), .tval(tval),
    .halted(halted), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // reference model state
  int          m_cnt = 0;
  logic [3:0]  m_cause = '0;
  logic [31:0] m_epc = '0, m_tval = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " cause"}, 64'(cause), 64'(m_cause));
    chk({tag, " epc"},   64'(epc),   64'(m_epc));
    chk({tag, " tval"},  64'(tval),  64'(m_tval));
    chk({tag, " count"}, 64'(trap_count), 64'(m_cnt));
  endtask

  // Inputs that must be ignored while the controller is busy.
  task automatic noise(input bit ack_ok, input bit res_ok);
    valid_in = 1'b1; trap_in = 1'($urandom); halt_in = 1'($urandom);
    pc_in = $urandom; instr_in = $urandom;
    host_ack = ack_ok & 1'($urandom);
    host_resume = res_ok & 1'($urandom);
  endtask

  task automatic quiet();
    valid_in = 0; trap_in = 0; halt_in = 0; host_ack = 0; host_resume = 0;
  endtask

  // One decode presentation, driven and checked from negedge to negedge.
  task automatic txn(input string tag, input logic v, input logic t, input logic h,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input int ack_dly, input int res_dly, input bit ack_res);
    bit ev = v & (t | h);
    logic [31:0] tgt;
    valid_in = v; trap_in = t; halt_in = h; pc_in = pc; instr_in = ins;
    @(negedge clk);
    if (!ev) begin
      quiet();
      chk({tag, " idle stall"}, 64'(stall), 0);
      chk({tag, " idle flush"}, 64'(flush), 0);
      chk({tag, " idle count"}, 64'(trap_count), 64'(m_cnt));
      return;
    end
    m_epc = pc; m_tval = ins; m_cause = t ? 4'd2 : 4'd3;
    if (t && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    tgt = t ? TV : pc + 32'd4;
    noise(1'b0, 1'b1);
    chk({tag, " flush"}, 64'({flush, stall, irq}), 64'(3'b110));
    @(negedge clk);
    chk({tag, " irq"}, 64'({flush, stall, irq}), 64'(3'b011));
    for (int i = 0; i < ack_dly; i++) begin
      noise(1'b0, 1'b1);
      @(negedge clk);
      chk({tag, " irq held"}, 64'({stall, irq}), 64'(2'b11));
    end
    noise(1'b0, 1'b0);
    host_ack = 1'b1; host_resume = ack_res;
    @(negedge clk);
    noise(1'b0, 1'b0);
    chk({tag, " irq drop"}, 64'({stall, irq, redirect_valid}), 64'(3'b100));
    if (t) begin
      chk({tag, " settle halted"}, 64'(halted), 0);
      @(negedge clk);
    end else begin
      chk({tag, " halted"}, 64'(halted), 1);
      for (int i = 0; i < res_dly; i++) begin
        noise(1'b1, 1'b0);
        @(negedge clk);
        chk({tag, " park"}, 64'({stall, halted, redirect_valid}), 64'(3'b110));
      end
      noise(1'b1, 1'b0);
      host_resume = 1'b1;
      @(negedge clk);
    end
    quiet();
    chk({tag, " redir"}, 64'({stall, halted, redirect_valid}), 64'(3'b101));
    chk({tag, " redir pc"}, 64'(redirect_pc), 64'(tgt));
    @(negedge clk);
    chk({tag, " run"}, 64'({stall, irq, redirect_valid, halted}), 64'(4'b0000));
    chk_state(tag);
  endtask

  initial begin
    // reset values
    rst = 1'b1; #12;
    chk("reset outs", 64'({stall, flush, irq, redirect_valid, halted}), 0);
    chk("reset regs", 64'({cause, redirect_pc}), 0);
    chk("reset count", 64'(trap_count), 0);
    @(negedge clk); rst = 1'b0; @(negedge clk);

    // directed: first trap, ack in first NOTIFY cycle (redirect four cycles after the event)
    txn("trap40", 1, 1, 0, 32'h40, 32'h0000_0000, 0, 0, 0);
    // halt at 0x80, ack after 5 irq cycles, resume 3 cycles later
    txn("halt80", 1, 0, 1, 32'h80, 32'h0000_007b, 4, 3, 0);
    // trap with valid_in low is ignored
    txn("novalid", 0, 1, 1, 32'h1234, 32'hdead_beef, 0, 0, 0);
    // both flags: trap wins
    txn("both", 1, 1, 1, 32'h200, 32'hffff_ffff, 1, 0, 0);
    // halt at top of memory wraps redirect to 0; ack and resume together on ack
    txn("wrap", 1, 0, 1, 32'hffff_fffc, 32'h0000_007b, 0, 2, 1);

    // async reset while irq is high
    valid_in = 1; trap_in = 1; pc_in = 32'h300; instr_in = 32'h1;
    @(negedge clk); quiet(); @(negedge clk);
    chk("pre-rst irq", 64'(irq), 1);
    #2 rst = 1'b1; #1;
    chk("rst async outs", 64'({stall, flush, irq, redirect_valid, halted}), 0);
    chk("rst async regs", 64'({cause, epc, tval, redirect_pc}), 0);
    chk("rst async count", 64'(trap_count), 0);
    m_cnt = 0; m_cause = 0; m_epc = 0; m_tval = 0;
    @(negedge clk); rst = 1'b0; @(negedge clk);
    txn("post-rst", 1, 1, 0, 32'h44, 32'h0, 0, 0, 0);

    // randomized transactions
    for (int k = 0; k < 150; k++) begin
      txn("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
          1'($urandom));
    end

    // saturation of the trap counter
    for (int k = 0; k < (1 << CNT_W) + 20; k++)
      txn("sat", 1, 1, 0, $urandom, $urandom, 0, 0, 0);
    chk("sat final", 64'(trap_count), 64'((1 << CNT_W) - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
